// File: rtl/bp_cce_hybrid_mem_cmd_arbiter_if.sv
// Signal bundle for the memory-command arbiter: writeback and request command streams in,
// merged CCE-MEM command stream out, plus the pending-bits write port.
interface bp_cce_hybrid_mem_cmd_arbiter_if #(
  parameter int paddr_width_p               = 40,
  parameter int mem_data_width_p            = 64,
  parameter int cce_mem_msg_header_width_lp = 80
);
  logic [cce_mem_msg_header_width_lp-1:0] wb_header_i;
  logic [mem_data_width_p-1:0]            wb_data_i;
  logic                                   wb_v_i;
  logic                                   wb_ready_and_o;
  logic                                   wb_last_i;

  logic [cce_mem_msg_header_width_lp-1:0] req_header_i;
  logic [mem_data_width_p-1:0]            req_data_i;
  logic                                   req_v_i;
  logic                                   req_ready_and_o;
  logic                                   req_last_i;

  logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_o;
  logic [mem_data_width_p-1:0]            mem_cmd_data_o;
  logic                                   mem_cmd_v_o;
  logic                                   mem_cmd_ready_and_i;
  logic                                   mem_cmd_last_o;

  logic                                   pending_w_v_o;
  logic                                   pending_w_yumi_i;
  logic [paddr_width_p-1:0]               pending_w_addr_o;
  logic                                   pending_w_addr_bypass_hash_o;
  logic                                   pending_up_o;
  logic                                   pending_down_o;
  logic                                   pending_clear_o;

  // arbiter side
  modport master (
    input  wb_header_i, wb_data_i, wb_v_i, wb_last_i,
    output wb_ready_and_o,
    input  req_header_i, req_data_i, req_v_i, req_last_i,
    output req_ready_and_o,
    output mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o,
    input  mem_cmd_ready_and_i,
    output pending_w_v_o, pending_w_addr_o, pending_w_addr_bypass_hash_o,
    output pending_up_o, pending_down_o, pending_clear_o,
    input  pending_w_yumi_i
  );

  // environment side: command sources, memory and pending-bits table
  modport slave (
    output wb_header_i, wb_data_i, wb_v_i, wb_last_i,
    input  wb_ready_and_o,
    output req_header_i, req_data_i, req_v_i, req_last_i,
    input  req_ready_and_o,
    input  mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o,
    output mem_cmd_ready_and_i,
    input  pending_w_v_o, pending_w_addr_o, pending_w_addr_bypass_hash_o,
    input  pending_up_o, pending_down_o, pending_clear_o,
    output pending_w_yumi_i
  );
endinterface

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter.sv
// Merges the writeback and request memory-command streams onto the CCE-MEM command port,
// round-robin per message, bumping the pending bit of each command address before streaming it.
module bp_cce_hybrid_mem_cmd_arbiter #(
  parameter int paddr_width_p               = 40,
  parameter int mem_data_width_p            = 64,
  parameter int cce_mem_msg_header_width_lp = 80,
  // bit position of the address field inside the BedRock header (above msg_type and subop)
  parameter int header_addr_lsb_p           = 8
) (
  input logic clk_i,
  input logic reset_i,
  bp_cce_hybrid_mem_cmd_arbiter_if.master io
);

  localparam int hw_lp = cce_mem_msg_header_width_lp;
  localparam int dw_lp = mem_data_width_p;

  typedef enum logic [1:0] {e_ready, e_pending, e_stream} state_e;

  // source index 0 = writeback, 1 = request
  logic [1:0][hw_lp-1:0] src_header;
  logic [1:0][dw_lp-1:0] src_data;
  logic [1:0]            src_v, src_last, src_ready;

  assign src_header = {io.req_header_i, io.wb_header_i};
  assign src_data   = {io.req_data_i,   io.wb_data_i};
  assign src_v      = {io.req_v_i,      io.wb_v_i};
  assign src_last   = {io.req_last_i,   io.wb_last_i};

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   rr_q, rr_d;          // 1: request wins the next tie
  logic   pend_v_q, pend_v_d;

  logic [hw_lp-1:0] grant_header;
  logic             beat_done;

  assign grant_header = src_header[grant_q];
  assign beat_done    = src_v[grant_q] & io.mem_cmd_ready_and_i;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    pend_v_d = 1'b0;
    unique case (state_q)
      e_ready: begin
        if (|src_v) begin
          grant_d  = (&src_v) ? rr_q : src_v[1];
          state_d  = e_pending;
          pend_v_d = 1'b1;
        end
      end
      e_pending: begin
        if (io.pending_w_yumi_i) state_d  = e_stream;
        else                     pend_v_d = 1'b1;
      end
      e_stream: begin
        if (beat_done & src_last[grant_q]) begin
          rr_d    = ~grant_q;
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_ready;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      pend_v_q <= pend_v_d;
    end
  end

  // Streaming is a straight combinational pass-through of the locked source.
  logic [hw_lp-1:0] mem_header;
  logic [dw_lp-1:0] mem_data;
  logic             mem_v, mem_last;

  always_comb begin
    mem_header = '0;
    mem_data   = '0;
    mem_v      = 1'b0;
    mem_last   = 1'b0;
    src_ready  = '0;
    if (state_q == e_stream) begin
      mem_header         = grant_header;
      mem_data           = src_data[grant_q];
      mem_v              = src_v[grant_q];
      mem_last           = src_last[grant_q];
      src_ready[grant_q] = io.mem_cmd_ready_and_i;
    end
  end

  assign io.mem_cmd_header_o = mem_header;
  assign io.mem_cmd_data_o   = mem_data;
  assign io.mem_cmd_v_o      = mem_v;
  assign io.mem_cmd_last_o   = mem_last;
  assign io.wb_ready_and_o   = src_ready[0];
  assign io.req_ready_and_o  = src_ready[1];

  assign io.pending_w_v_o                = pend_v_q;
  assign io.pending_w_addr_o             = pend_v_q
                                           ? grant_header[header_addr_lsb_p +: paddr_width_p]
                                           : '0;
  assign io.pending_up_o                 = pend_v_q;
  assign io.pending_w_addr_bypass_hash_o = 1'b0;
  assign io.pending_down_o               = 1'b0;
  assign io.pending_clear_o              = 1'b0;

  a_grant_header_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q != e_ready && $past(state_q) != e_ready) |-> grant_header == $past(grant_header));

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    io.pending_w_yumi_i |-> pend_v_q);

endmodule
